// File: rtl/rails_pkg.sv
// Shared parameters and types for the rails departure-order frame generator.
package rails_pkg;

    localparam int MAX_N   = 10;
    localparam int DW      = 4;
    localparam int TIMEOUT = 8;

    typedef logic [DW-1:0] coach_t;

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        SEND_LEN,
        SEND,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/rails_stack.sv
// Station stack: LIFO of coach numbers with synchronous clear.
// push and pop are never requested in the same cycle by the frame generator.
module rails_stack #(
    parameter int DEPTH = rails_pkg::MAX_N
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  rails_pkg::coach_t            din,
    output rails_pkg::coach_t            top,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    import rails_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    coach_t        mem_q [DEPTH];
    coach_t        mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;

    // Next stack contents: clear wins, then push (if not full), then pop (if not empty).
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear) begin
            mem_d   = '{default: '0};
            count_d = '0;
        end else if (push && (count_q != CW'(DEPTH))) begin
            mem_d[IW'(count_q)] = din;
            count_d             = count_q + 1'b1;
        end else if (pop && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Stack storage and depth registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= '{default: '0};
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign top   = (count_q != '0) ? mem_q[IW'(count_q - 1'b1)] : '0;

endmodule

// File: rtl/rails_frame_gen.sv
// Transmit side of the rails departure-order protocol: builds a stack-legal
// departure order from len/ops, streams N then the order on data, and waits
// for the checker's verdict (or times out).
module rails_frame_gen #(
    parameter int MAX_N   = rails_pkg::MAX_N,
    parameter int DW      = rails_pkg::DW,
    parameter int TIMEOUT = rails_pkg::TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DW-1:0]        len,
    input  logic [2*MAX_N-1:0]   ops,
    output logic                 busy,
    output logic [DW-1:0]        data,
    input  logic                 chk_valid,
    input  logic                 chk_result,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic                 err,
    output rails_pkg::state_e    dbg_state
);
    import rails_pkg::*;

    localparam int CW = $clog2(MAX_N + 1);
    localparam int IW = $clog2(MAX_N);
    localparam int SW = $clog2(2 * MAX_N);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [DW-1:0]      len_q, len_d;
    logic [2*MAX_N-1:0] ops_q, ops_d;
    logic [CW-1:0]      push_cnt_q, push_cnt_d;
    logic [CW-1:0]      pop_cnt_q, pop_cnt_d;
    logic [CW-1:0]      idx_q, idx_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [DW-1:0]      out_buf_q [MAX_N];
    logic [DW-1:0]      out_buf_d [MAX_N];
    logic [DW-1:0]      data_q, data_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic               err_q, err_d;

    logic               stk_clear, stk_push, stk_pop, stk_empty;
    coach_t             stk_top;
    logic [CW-1:0]      stk_count;
    logic [SW-1:0]      step;

    rails_stack #(.DEPTH(MAX_N)) u_stack (
        .clk   (clk),
        .reset (reset),
        .clear (stk_clear),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (coach_t'(push_cnt_q + 1'b1)),
        .top   (stk_top),
        .empty (stk_empty),
        .count (stk_count)
    );

    // Build step index: every BUILD cycle is exactly one push or one pop.
    assign step = SW'(push_cnt_q) + SW'(pop_cnt_q);

    // Next-state, counters, buffer writes and the registered output values.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ops_d      = ops_q;
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        out_buf_d  = out_buf_q;
        data_d     = '0;
        done_d     = 1'b0;
        pass_d     = 1'b0;
        timeout_d  = 1'b0;
        err_d      = 1'b0;
        stk_clear  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((len != '0) && (len <= DW'(MAX_N))) begin
                        len_d      = len;
                        ops_d      = ops;
                        push_cnt_d = '0;
                        pop_cnt_d  = '0;
                        stk_clear  = 1'b1;
                        state_d    = BUILD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BUILD: begin
                // Empty stack forces a push; all coaches already pushed forces a pop.
                if (stk_empty || ((push_cnt_q != CW'(len_q)) && ops_q[step])) begin
                    stk_push   = 1'b1;
                    push_cnt_d = push_cnt_q + 1'b1;
                end else begin
                    stk_pop                    = 1'b1;
                    out_buf_d[IW'(pop_cnt_q)]  = stk_top;
                    pop_cnt_d                  = pop_cnt_q + 1'b1;
                    if ((push_cnt_q == CW'(len_q)) && (stk_count == CW'(1))) begin
                        state_d = SEND_LEN;
                    end
                end
            end
            SEND_LEN: begin
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (idx_q == (CW'(len_q) - 1'b1)) begin
                    timer_d = '0;
                    state_d = WAIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WAIT: begin
                if (chk_valid) begin
                    done_d  = 1'b1;
                    pass_d  = chk_result;
                    state_d = DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // data is registered: load the value that belongs to the state being entered.
        case (state_d)
            SEND_LEN: data_d = len_q;
            SEND:     data_d = out_buf_d[IW'(idx_d)];
            default:  data_d = '0;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            ops_q      <= '0;
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            out_buf_q  <= '{default: '0};
            data_q     <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ops_q      <= ops_d;
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            out_buf_q  <= out_buf_d;
            data_q     <= data_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
        end
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign data      = data_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rails_frame_gen.sv
// Directed bench for rails_frame_gen: frame contents, latency, verdict capture,
// timeout, start rejection and mid-frame reset.
module tb_rails_frame_gen;
    import rails_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic [19:0] ops = '0;
    logic        chk_valid = 1'b0;
    logic        chk_result = 1'b0;
    logic        busy, done, pass, timeout, err;
    logic [3:0]  data;
    state_e      dbg_state;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  exp_q[$];

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    rails_frame_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .ops        (ops),
        .busy       (busy),
        .data       (data),
        .chk_valid  (chk_valid),
        .chk_result (chk_result),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame; expected data values must already be in exp_q.
    // Latency counts the start-sampling edge, so first data shows after 2N+1 edges.
    task automatic run_frame(input int n, input logic [19:0] ops_v, input bit to_mode,
                             input bit res, input int delay, input bit noise);
        int         cycles;
        int         wait_cnt;
        bit         err_seen;
        logic [3:0] e;
        start      = 1'b1;
        len        = n[3:0];
        ops        = ops_v;
        chk_valid  = noise;
        chk_result = noise;
        tick();
        start = 1'b0;
        len   = '0;
        check_eq("busy_on", busy, 1);
        cycles   = 1;
        err_seen = 1'b0;
        while (data == 0 && cycles < 100) begin
            start = (cycles == 2);
            tick();
            cycles++;
            err_seen |= err;
        end
        start = 1'b0;
        check_eq("latency", cycles, 2 * n + 1);
        check_eq("err_while_busy", err_seen, 0);
        for (int i = 0; i <= n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
            check_eq($sformatf("data%0d", i), data, e);
            if (i == n) begin
                chk_valid  = 1'b0;
                chk_result = 1'b0;
            end
            tick();
        end
        check_eq("wait_data0", data, 0);
        if (!to_mode) begin
            for (int j = 0; j < delay; j++) tick();
            chk_valid  = 1'b1;
            chk_result = res;
            tick();
            chk_valid  = 1'b0;
            chk_result = 1'b0;
            check_eq("done", done, 1);
            check_eq("pass", pass, res);
            check_eq("timeout0", timeout, 0);
            check_eq("busy_off", busy, 0);
        end else begin
            wait_cnt = 0;
            while (!done && wait_cnt < 50) begin
                tick();
                wait_cnt++;
            end
            check_eq("to_cycles", wait_cnt, 8);
            check_eq("timeout1", timeout, 1);
            check_eq("to_pass0", pass, 0);
            check_eq("to_busy_off", busy, 0);
        end
        tick();
        check_eq("flags_clear", {done, pass, timeout}, 0);
    endtask

    task automatic bad_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        ops   = 20'hFFFFF;
        tick();
        start = 1'b0;
        len   = '0;
        check_eq("err_pulse", err, 1);
        check_eq("err_busy0", busy, 0);
        check_eq("err_data0", data, 0);
        tick();
        check_eq("err_clear", err, 0);
        check_eq("err_idle", dbg_state, IDLE);
    endtask

    // Stimulus and final report
    initial begin
        int cyc;
        bit done_seen;
        repeat (2) tick();
        check_eq("rst_outputs", {busy, done, pass, timeout, err, data}, 0);
        check_eq("rst_state", dbg_state, IDLE);
        reset = 1'b1;
        tick();

        // push 1,2,3 then pop 3,2,1
        exp_q = '{4'd3, 4'd3, 4'd2, 4'd1};
        run_frame(3, 20'b000111, 1'b0, 1'b1, 0, 1'b0);

        // alternating push/pop gives 1,2,3; negative verdict after 2 WAIT cycles
        exp_q = '{4'd3, 4'd1, 4'd2, 4'd3};
        run_frame(3, 20'b010101, 1'b0, 1'b0, 2, 1'b0);

        // all-pop ops force push/pop; ops bits above 2N are ignored
        exp_q = '{4'd2, 4'd1, 4'd2};
        run_frame(2, 20'hFFFF0, 1'b0, 1'b1, 0, 1'b0);

        // full-length frame, all push: forced pops at the end
        exp_q.delete();
        exp_q.push_back(4'd10);
        for (int c = 10; c >= 1; c--) exp_q.push_back(4'(c));
        run_frame(10, 20'hFFFFF, 1'b0, 1'b1, 1, 1'b0);

        // rejected lengths
        bad_start(4'd0);
        bad_start(4'd11);

        // timeout, with verdict strobes outside WAIT that must be ignored
        exp_q = '{4'd4, 4'd1, 4'd2, 4'd4, 4'd3};
        run_frame(4, 20'b00110101, 1'b1, 1'b0, 0, 1'b1);

        // reset on the second SEND cycle aborts the frame
        start = 1'b1;
        len   = 4'd3;
        ops   = 20'b000111;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (data == 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        tick();
        check_eq("pre_rst_send0", data, 3);
        tick();
        check_eq("pre_rst_send1", data, 2);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_outputs", {busy, done, pass, timeout, err, data}, 0);
        check_eq("mid_rst_state", dbg_state, IDLE);
        done_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            done_seen |= done;
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            done_seen |= done;
        end
        check_eq("no_done_after_rst", done_seen, 0);

        exp_q = '{4'd1, 4'd1};
        run_frame(1, 20'h0, 1'b0, 1'b1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
